load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 142 ++++++++++++++
 tb/tb_load_store_unit.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: one outstanding LW/LBU/SW/SB op, memory request/response handshake, timeout.
// Optional macro LSU_MISALIGN_TRAP_EN turns misaligned word ops into an immediate error.
module load_store_unit #(
  parameter int unsigned RSP_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        valid_i,
  input  logic        is_load_i,
  input  logic        is_byte_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] store_data_i,
  output logic        ready_o,
  output logic        mem_req_valid_o,
  output logic        mem_req_write_o,
  output logic [31:0] mem_req_addr_o,
  output logic [31:0] mem_req_wdata_o,
  output logic [3:0]  mem_req_wmask_o,
  input  logic        mem_req_ready_i,
  input  logic        mem_rsp_valid_i,
  input  logic [31:0] mem_rsp_data_i,
  output logic        load_valid_o,
  output logic [31:0] load_data_o,
  output logic        store_done_o,
  output logic        err_o
);

  typedef enum logic [1:0] {StIdle, StReq, StWaitRsp, StDone} state_e;

  localparam logic [15:0] TimeoutLast = 16'(RSP_TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        is_load_q, is_load_d;
  logic        is_byte_q, is_byte_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [31:0] load_data_q, load_data_d;
  logic        trap;
  logic [7:0]  rsp_byte;

`ifdef LSU_MISALIGN_TRAP_EN
  assign trap = !is_byte_i && (addr_i[1:0] != 2'b00);
`else
  assign trap = 1'b0;
`endif

  assign rsp_byte = mem_rsp_data_i[8*addr_q[1:0] +: 8];

  always_comb begin
    state_d     = state_q;
    is_load_d   = is_load_q;
    is_byte_d   = is_byte_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    load_data_d = load_data_q;
    unique case (state_q)
      StIdle: begin
        if (valid_i) begin
          is_load_d = is_load_i;
          is_byte_d = is_byte_i;
          addr_d    = addr_i;
          wdata_d   = store_data_i;
          err_d     = trap;
          if (trap) begin
            state_d = StDone;
            if (is_load_i) load_data_d = '0;
          end else begin
            state_d = StReq;
          end
        end
      end
      StReq: begin
        cnt_d = '0;
        if (mem_req_ready_i) state_d = is_load_q ? StWaitRsp : StDone;
      end
      StWaitRsp: begin
        // A response arriving in the last allowed cycle beats the timeout.
        if (mem_rsp_valid_i) begin
          load_data_d = is_byte_q ? {24'h0, rsp_byte} : mem_rsp_data_i;
          state_d     = StDone;
        end else if (cnt_q == TimeoutLast) begin
          err_d       = 1'b1;
          load_data_d = '0;
          state_d     = StDone;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= StIdle;
      is_load_q   <= 1'b0;
      is_byte_q   <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      load_data_q <= '0;
    end else begin
      state_q     <= state_d;
      is_load_q   <= is_load_d;
      is_byte_q   <= is_byte_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      load_data_q <= load_data_d;
    end
  end

  logic in_req, in_wr, in_done;

  always_comb begin
    in_req          = (state_q == StReq);
    in_wr           = in_req && !is_load_q;
    in_done         = (state_q == StDone);
    ready_o         = (state_q == StIdle);
    mem_req_valid_o = in_req;
    mem_req_write_o = in_wr;
    mem_req_addr_o  = in_req ? {addr_q[31:2], 2'b00} : 32'h0;
    mem_req_wdata_o = 32'h0;
    mem_req_wmask_o = 4'h0;
    if (in_wr) begin
      mem_req_wdata_o = is_byte_q ? {4{wdata_q[7:0]}} : wdata_q;
      mem_req_wmask_o = is_byte_q ? (4'b0001 << addr_q[1:0]) : 4'hF;
    end
    load_valid_o = in_done && is_load_q && !err_q;
    store_done_o = in_done && !is_load_q && !err_q;
    err_o        = in_done && err_q;
    load_data_o  = load_data_q;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: random ops driven with a reference model, monitor checks.
module tb_load_store_unit;
  localparam int T = 8;

  logic        clk = 1'b0;
  logic        n_reset;
  logic        valid_i, is_load_i, is_byte_i;
  logic [31:0] addr_i, store_data_i;
  logic        ready_o, mem_req_valid_o, mem_req_write_o;
  logic [31:0] mem_req_addr_o, mem_req_wdata_o;
  logic [3:0]  mem_req_wmask_o;
  logic        mem_req_ready_i, mem_rsp_valid_i;
  logic [31:0] mem_rsp_data_i;
  logic        load_valid_o, store_done_o, err_o;
  logic [31:0] load_data_o;

  load_store_unit #(.RSP_TIMEOUT(T)) dut (
    .clk(clk), .n_reset(n_reset), .valid_i(valid_i), .is_load_i(is_load_i),
    .is_byte_i(is_byte_i), .addr_i(addr_i), .store_data_i(store_data_i), .ready_o(ready_o),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_write_o(mem_req_write_o),
    .mem_req_addr_o(mem_req_addr_o), .mem_req_wdata_o(mem_req_wdata_o),
    .mem_req_wmask_o(mem_req_wmask_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_data_i(mem_rsp_data_i),
    .load_valid_o(load_valid_o), .load_data_o(load_data_o), .store_done_o(store_done_o),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  m;
  } req_t;
  typedef struct {
    int          kind;  // 0 store done, 1 load valid, 2 error
    int          cyc;
    logic [31:0] data;
    bit          is_load;
  } rsp_t;

  req_t        exp_req_q[$];
  rsp_t        exp_rsp_q[$];
  logic [31:0] exp_ld = 32'h0;
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  bit          mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: compares every presented request and completion pulse against the queues.
  req_t r;
  rsp_t e;
  int   npulse, act_kind;
  always @(negedge clk) begin
    if (n_reset && mon_en) begin
      chk("ready_o", 32'(ready_o), 32'(exp_rsp_q.size() == 0));
      if (mem_req_valid_o) begin
        if (exp_req_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_req: got addr %h want no request", mem_req_addr_o);
        end else begin
          r = exp_req_q[0];
          chk("req_write", 32'(mem_req_write_o), 32'(r.w));
          chk("req_addr", mem_req_addr_o, r.a);
          chk("req_wmask", 32'(mem_req_wmask_o), 32'(r.m));
          if (r.w) chk("req_wdata", mem_req_wdata_o, r.d);
          if (mem_req_ready_i) void'(exp_req_q.pop_front());
        end
      end
      npulse = int'(load_valid_o) + int'(store_done_o) + int'(err_o);
      if (npulse != 0) begin
        if (exp_rsp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_pulse: got lv=%0b sd=%0b err=%0b want none",
                   load_valid_o, store_done_o, err_o);
        end else begin
          e = exp_rsp_q.pop_front();
          act_kind = err_o ? 2 : (load_valid_o ? 1 : 0);
          chk("pulse_onehot", 32'(npulse), 32'd1);
          chk("pulse_kind", 32'(act_kind), 32'(e.kind));
          chk("pulse_cycle", 32'(cyc), 32'(e.cyc));
          if (e.is_load) exp_ld = e.data;
        end
      end
      chk("load_data", load_data_o, exp_ld);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Junk on every input the unit should ignore while busy.
  task automatic busy();
    valid_i         = 1'($urandom);
    is_load_i       = 1'($urandom);
    is_byte_i       = 1'($urandom);
    addr_i          = $urandom;
    store_data_i    = $urandom;
    mem_req_ready_i = 1'($urandom);
    mem_rsp_valid_i = 1'($urandom);
    mem_rsp_data_i  = $urandom;
  endtask

  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      busy();
      valid_i = 1'b0;
      step();
    end
    valid_i         = 1'b0;
    mem_rsp_valid_i = 1'b0;
  endtask

  // stall: REQ cycles with memory not ready; delay: WAIT_RSP cycles before the response.
  task automatic do_op(input bit ld, input bit byt, input logic [31:0] a, input logic [31:0] d,
                       input int stall, input int delay, input logic [31:0] rdata);
    int   acc, n;
    bit   trap;
    req_t rq;
    rsp_t rs;
    trap = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    trap = !byt && (a[1:0] != 2'b00);
`endif
    valid_i = 1'b1; is_load_i = ld; is_byte_i = byt; addr_i = a; store_data_i = d;
    mem_req_ready_i = 1'b0; mem_rsp_valid_i = 1'b0;
    acc = cyc;
    rq.w = !ld;
    rq.a = {a[31:2], 2'b00};
    rq.d = byt ? {4{d[7:0]}} : d;
    rq.m = ld ? 4'h0 : (byt ? (4'b0001 << a[1:0]) : 4'hF);
    rs.is_load = ld;
    if (trap) begin
      rs.kind = 2; rs.cyc = acc + 1; rs.data = 32'h0;
    end else if (!ld) begin
      rs.kind = 0; rs.cyc = acc + 2 + stall; rs.data = 32'h0;
    end else if (delay < T) begin
      rs.kind = 1; rs.cyc = acc + 3 + stall + delay;
      rs.data = byt ? ((rdata >> (8 * a[1:0])) & 32'hFF) : rdata;
    end else begin
      rs.kind = 2; rs.cyc = acc + 2 + stall + T; rs.data = 32'h0;
    end
    @(posedge clk);
    if (!trap) exp_req_q.push_back(rq);
    exp_rsp_q.push_back(rs);
    #1;
    if (!trap) begin
      for (int k = 0; k <= stall; k++) begin
        busy();
        mem_req_ready_i = (k == stall);
        step();
      end
      if (ld) begin
        n = (delay < T) ? delay + 1 : T;
        for (int w = 0; w < n; w++) begin
          busy();
          mem_rsp_valid_i = (w == delay);
          mem_rsp_data_i  = (w == delay) ? rdata : $urandom;
          step();
        end
      end
    end
    busy();
    step();
    valid_i = 1'b0; mem_rsp_valid_i = 1'b0; mem_req_ready_i = 1'b0;
  endtask

  task automatic reset_in_wait();
    rsp_t rs;
    req_t rq;
    valid_i = 1'b1; is_load_i = 1'b1; is_byte_i = 1'b0; addr_i = 32'h400;
    @(posedge clk);
    rq.w = 1'b0; rq.a = 32'h400; rq.d = 32'h0; rq.m = 4'h0;
    exp_req_q.push_back(rq);
    rs.kind = 1; rs.cyc = -1; rs.data = 32'h0; rs.is_load = 1'b1;
    exp_rsp_q.push_back(rs);
    #1;
    valid_i = 1'b0; mem_req_ready_i = 1'b1;
    step();
    mem_req_ready_i = 1'b0;
    repeat (3) step();
    #2;
    n_reset = 1'b0;
    #1;
    chk("rst_ready", 32'(ready_o), 32'd1);
    chk("rst_req_valid", 32'(mem_req_valid_o), 32'd0);
    chk("rst_pulses", {29'h0, load_valid_o, store_done_o, err_o}, 32'd0);
    chk("rst_load_data", load_data_o, 32'h0);
    exp_req_q.delete();
    exp_rsp_q.delete();
    exp_ld = 32'h0;
    step();
    n_reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mem_rsp_valid_i = 1'b1;
      mem_rsp_data_i  = $urandom;
      step();
    end
    mem_rsp_valid_i = 1'b0;
    chk("stray_rsp_ready", 32'(ready_o), 32'd1);
  endtask

  initial begin
    n_reset = 1'b0;
    valid_i = 1'b0; is_load_i = 1'b0; is_byte_i = 1'b0; addr_i = '0; store_data_i = '0;
    mem_req_ready_i = 1'b0; mem_rsp_valid_i = 1'b0; mem_rsp_data_i = '0;
    repeat (3) step();
    chk("reset_ready", 32'(ready_o), 32'd1);
    chk("reset_outputs", {26'h0, mem_req_valid_o, mem_req_write_o, mem_req_wmask_o != 4'h0,
                          load_valid_o, store_done_o, err_o}, 32'd0);
    chk("reset_req_addr", mem_req_addr_o, 32'h0);
    chk("reset_load_data", load_data_o, 32'h0);
    n_reset = 1'b1;
    mon_en  = 1'b1;
    step();

    do_op(1'b0, 1'b0, 32'h100, 32'hDEADBEEF, 0, 0, 32'h0);
    do_op(1'b0, 1'b1, 32'h103, 32'h0000005A, 0, 0, 32'h0);
    do_op(1'b1, 1'b1, 32'h202, 32'h0, 0, 2, 32'h11223344);
    do_op(1'b1, 1'b0, 32'h204, 32'h0, 4, 1000, 32'h0);
    do_op(1'b1, 1'b0, 32'h301, 32'h0, 1, 0, 32'hCAFEF00D);
    do_op(1'b1, 1'b0, 32'h308, 32'h0, 0, T - 1, 32'h12345678);
    do_op(1'b1, 1'b0, 32'h30C, 32'h0, 0, T, 32'h87654321);
    do_op(1'b0, 1'b0, 32'h402, 32'h01020304, 2, 0, 32'h0);
    idle_gap(2);

    for (int i = 0; i < 60; i++) begin
      do_op(1'($urandom), 1'($urandom), $urandom, $urandom, int'($urandom_range(0, 3)),
            int'($urandom_range(0, 10)), $urandom);
      idle_gap(int'($urandom_range(0, 2)));
    end

    reset_in_wait();
    do_op(1'b1, 1'b1, 32'h501, 32'h0, 0, 0, 32'hA1B2C3D4);
    idle_gap(2);

    chk("drain_req", 32'(exp_req_q.size()), 32'd0);
    chk("drain_rsp", 32'(exp_rsp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
